// File: rtl/alu_op_dispatch_decoder.sv
// Dispatch decoder: accepts an ALU op-select, holds a one-hot sub-unit enable for HOLD_CYCLES, then pulses done.
// Latency: enable rises the cycle after accept, done follows the hold period, in_ready returns one cycle after done.
// Backpressure: in_ready is high only in IDLE; requesters hold until accepted. Optional DEC_PERF_CNT_EN adds disp_cnt.
module alu_op_dispatch_decoder #(
  parameter int SEL_W       = 2,
  parameter int NUM_OUT     = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   in_sel,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out_en,
  output logic [SEL_W-1:0]   out_sel_q,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef DEC_PERF_CNT_EN
  ,
  output logic [15:0]        disp_cnt
`endif
);

  // Hold counter only needs to reach HOLD_CYCLES-1; keep at least one bit.
  localparam int                CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  // One extra bit so NUM_OUT == 2**SEL_W is representable in the range check.
  localparam logic [SEL_W:0]    NUM_OUT_V = (SEL_W + 1)'(NUM_OUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             accept;
  logic             legal;

  // Ready is a pure state decode; acceptance and range check feed only registers.
  always_comb begin
    in_ready = (state == ST_IDLE);
    accept   = in_valid && in_ready;
    legal    = ({1'b0, in_sel} < NUM_OUT_V);
  end

  // Main dispatch FSM with registered enable, select copy and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_en    <= '0;
      out_sel_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (legal) begin
              state     <= ST_ACTIVE;
              out_en    <= NUM_OUT'(1) << in_sel;
              out_sel_q <= in_sel;
              hold_cnt  <= HOLD_INIT;
              busy      <= 1'b1;
            end else begin
              // Illegal select: flag it and stay ready for the next request.
              err <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end else begin
            state  <= ST_DONE;
            out_en <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          out_en <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEC_PERF_CNT_EN
  // Count legal dispatches; wraps naturally at 16 bits, illegal selects ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_cnt <= '0;
    end else if (accept && legal) begin
      disp_cnt <= disp_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_dispatch_decoder.sv
// Bench for alu_op_dispatch_decoder: main instance SEL_W=3/NUM_OUT=6/HOLD_CYCLES=3,
// second instance with defaults (SEL_W=2/NUM_OUT=4/HOLD_CYCLES=1).
// Expected values come from a timeline model keyed on the edge of the last legal accept.
module tb_alu_op_dispatch_decoder;

  localparam int SW = 3;
  localparam int N  = 6;
  localparam int H  = 3;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic          rst;
  logic          in_valid;
  logic [SW-1:0] in_sel;
  logic          in_ready;
  logic [N-1:0]  out_en;
  logic [SW-1:0] out_sel_q;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   disp_cnt;

  // Default-parameter instance signals
  logic          r2;
  logic          v2;
  logic [1:0]    s2;
  logic          rdy2;
  logic [3:0]    en2;
  logic [1:0]    selq2;
  logic          busy2;
  logic          done2;
  logic          err2;
  logic [15:0]   cnt2;

  alu_op_dispatch_decoder #(.SEL_W(SW), .NUM_OUT(N), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
    .out_en(out_en), .out_sel_q(out_sel_q), .busy(busy), .done(done), .err(err)
`ifdef DEC_PERF_CNT_EN
    , .disp_cnt(disp_cnt)
`endif
  );

  alu_op_dispatch_decoder dut2 (
    .clk(clk), .rst(r2), .in_valid(v2), .in_sel(s2), .in_ready(rdy2),
    .out_en(en2), .out_sel_q(selq2), .busy(busy2), .done(done2), .err(err2)
`ifdef DEC_PERF_CNT_EN
    , .disp_cnt(cnt2)
`endif
  );

`ifndef DEC_PERF_CNT_EN
  assign disp_cnt = 16'd0;
  assign cnt2     = 16'd0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: edge counter, edge of last legal accept, latched select/err/count.
  int          edge_n   = 0;
  int          last_acc = -100;
  logic [2:0]  m_selq   = '0;
  logic        m_err    = 1'b0;
  logic [15:0] m_cnt    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the main instance, advance the model, then compare every output.
  task automatic tick(input logic v, input logic [2:0] s, input logic r);
    bit         ready_pre;
    int         d;
    logic [5:0] e_en;
    in_valid = v;
    in_sel   = s;
    rst      = r;
    @(posedge clk);
    edge_n++;
    ready_pre = ((edge_n - 1 - last_acc) >= H + 1);
    m_err = 1'b0;
    if (r) begin
      last_acc = -100;
      m_selq   = '0;
      m_cnt    = '0;
    end else if (v && ready_pre) begin
      if (int'(s) < N) begin
        last_acc = edge_n;
        m_selq   = s;
        m_cnt    = m_cnt + 16'd1;
      end else begin
        m_err = 1'b1;
      end
    end
    #1;
    d    = edge_n - last_acc;
    e_en = (d >= 0 && d <= H - 1) ? (6'd1 << m_selq) : 6'd0;
    chk("out_en",    32'(out_en),    32'(e_en));
    chk("busy",      32'(busy),      32'(d >= 0 && d <= H - 1));
    chk("done",      32'(done),      32'(d == H));
    chk("in_ready",  32'(in_ready),  32'(d >= H + 1));
    chk("err",       32'(err),       32'(m_err));
    chk("out_sel_q", 32'(out_sel_q), 32'(m_selq));
    chk("onehot0",   32'($onehot0(out_en)), 32'd1);
`ifdef DEC_PERF_CNT_EN
    chk("disp_cnt",  32'(disp_cnt),  32'(m_cnt));
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0;
    r2 = 1'b1;  v2 = 1'b0;       s2 = '0;

    // Reset then idle
    tick(1'b0, 3'd0, 1'b1);
    tick(1'b0, 3'd0, 1'b1);
    tick(1'b0, 3'd0, 1'b0);

    // Legal dispatch of unit 2, then observe hold, done and return to ready
    tick(1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 3'd0, 1'b0);

    // Back-to-back illegal selects
    tick(1'b1, 3'd7, 1'b0);
    tick(1'b1, 3'd6, 1'b0);
    tick(1'b0, 3'd0, 1'b0);

    // Busy backpressure: unit 1 in flight while unit 5 is held pending
    tick(1'b1, 3'd1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 3'd5, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 3'd0, 1'b0);

    // Reset during the second ACTIVE cycle
    tick(1'b1, 3'd4, 1'b0);
    tick(1'b0, 3'd0, 1'b0);
    tick(1'b0, 3'd0, 1'b1);
    tick(1'b0, 3'd0, 1'b0);
    tick(1'b0, 3'd0, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
    end
    tick(1'b0, 3'd0, 1'b0);

    // Default instance: HOLD_CYCLES=1, all selects legal
    @(posedge clk); #1;
    r2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    r2 = 1'b0;
    chk("d2_rst_ready", 32'(rdy2), 32'd1);
    chk("d2_rst_en",    32'(en2),  32'd0);
    for (int i = 0; i < 5; i++) begin
      logic [1:0] sel;
      logic [3:0] exp_en;
      sel    = 2'(i % 4);
      exp_en = 4'd1 << sel;
      v2 = 1'b1;
      s2 = sel;
      @(posedge clk); #1;
      v2 = 1'b0;
      chk("d2_en",    32'(en2),   32'(exp_en));
      chk("d2_busy",  32'(busy2), 32'd1);
      chk("d2_ready", 32'(rdy2),  32'd0);
      chk("d2_selq",  32'(selq2), 32'(sel));
      @(posedge clk); #1;
      chk("d2_en_off", 32'(en2),   32'd0);
      chk("d2_done",   32'(done2), 32'd1);
      chk("d2_err",    32'(err2),  32'd0);
      @(posedge clk); #1;
      chk("d2_done_end", 32'(done2), 32'd0);
      chk("d2_ready_back", 32'(rdy2), 32'd1);
    end
`ifdef DEC_PERF_CNT_EN
    chk("d2_disp_cnt", 32'(cnt2), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
